dvs_aer_multi_event_interface: RTL and testbench



---
 rtl/dvs_ravens_pkg.sv | 24 ++
 rtl/dvs_aer_rx_channel.sv | 102 ++++++++++
 rtl/dvs_aer_multi_event_interface.sv | 137 +++++++++++++
 tb/tb_dvs_aer_multi_event_interface.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dvs_ravens_pkg.sv
// Shared constants and event-word layout for the DVS AER multi-channel interface.
// Defining DVS_TIMESTAMP_EN widens the event word by a TS_BITS cycle timestamp.
package dvs_ravens_pkg;

  localparam int CH_ID_BITS    = 3;
  localparam int TS_BITS       = 16;
  localparam int DEF_ADDR_BITS = 9;

  typedef struct packed {
    logic [CH_ID_BITS-1:0]    chId;
    logic [DEF_ADDR_BITS-1:0] y;
    logic [DEF_ADDR_BITS-1:0] x;
    logic                     pol;
  } dvs_event_t;

  function automatic int event_w(input int addrBits);
`ifdef DVS_TIMESTAMP_EN
    return CH_ID_BITS + 2 * addrBits + 1 + TS_BITS;
`else
    return CH_ID_BITS + 2 * addrBits + 1;
`endif
  endfunction

endpackage

// File: rtl/dvs_aer_rx_channel.sv
// One AER sender channel: request synchronizer plus the Y/X capture and
// four-phase handshake FSM; X words are offered to the shared arbiter.
module dvs_aer_rx_channel
  import dvs_ravens_pkg::*;
#(
  parameter int ADDR_BITS      = 9,
  parameter int Y_SETUP_CYCLES = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS:0]   i_aer,
  input  logic                 i_xsel,
  input  logic                 i_req,
  input  logic                 i_grant,
  output logic                 o_ack,
  output logic                 o_pushReq,
  output logic [ADDR_BITS-1:0] o_x,
  output logic [ADDR_BITS-1:0] o_y,
  output logic                 o_pol,
  output logic                 o_errNoY
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_Y_WAIT = 3'd1;
  localparam logic [2:0] ST_PUSH   = 3'd2;
  localparam logic [2:0] ST_ACK_HI = 3'd3;
  localparam logic [2:0] ST_ACK_LO = 3'd4;

  localparam int CNT_W = (Y_SETUP_CYCLES > 1) ? $clog2(Y_SETUP_CYCLES) : 1;

  logic [2:0]           r_state;
  logic [2:0]           w_stateNext;
  logic                 r_reqMeta;
  logic                 r_reqSync;
  logic [CNT_W-1:0]     r_setupCnt;
  logic [ADDR_BITS-1:0] r_x;
  logic [ADDR_BITS-1:0] r_y;
  logic                 r_pol;
  logic                 r_yValid;
  logic                 r_ack;
  logic                 r_errNoY;

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE:   if (r_reqSync) w_stateNext = i_xsel ? ST_PUSH : ST_Y_WAIT;
      ST_Y_WAIT: if (r_setupCnt == CNT_W'(Y_SETUP_CYCLES - 1)) w_stateNext = ST_ACK_HI;
      ST_PUSH:   if (!r_yValid || i_grant) w_stateNext = ST_ACK_HI;
      ST_ACK_HI: if (!r_reqSync) w_stateNext = ST_ACK_LO;
      ST_ACK_LO: w_stateNext = ST_IDLE;
      default:   w_stateNext = ST_IDLE;
    endcase
  end

  // Ack is a register that follows the next state, so it is high exactly
  // while in ACK_HI and only after the word has been latched or buffered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reqMeta  <= 1'b0;
      r_reqSync  <= 1'b0;
      r_state    <= ST_IDLE;
      r_setupCnt <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_pol      <= 1'b0;
      r_yValid   <= 1'b0;
      r_ack      <= 1'b0;
      r_errNoY   <= 1'b0;
    end else begin
      r_reqMeta <= i_req;
      r_reqSync <= r_reqMeta;
      r_state   <= w_stateNext;
      r_ack     <= (w_stateNext == ST_ACK_HI);

      if (r_state == ST_Y_WAIT)
        r_setupCnt <= r_setupCnt + CNT_W'(1);
      else
        r_setupCnt <= '0;

      if (r_state == ST_Y_WAIT && w_stateNext == ST_ACK_HI) begin
        r_y      <= i_aer[ADDR_BITS-1:0];
        r_yValid <= 1'b1;
      end

      if (r_state == ST_IDLE && r_reqSync && i_xsel) begin
        r_x   <= i_aer[ADDR_BITS:1];
        r_pol <= i_aer[0];
      end

      if (r_state == ST_PUSH && !r_yValid)
        r_errNoY <= 1'b1;
    end
  end

  assign o_pushReq = (r_state == ST_PUSH) && r_yValid;
  assign o_ack     = r_ack;
  assign o_x       = r_x;
  assign o_y       = r_y;
  assign o_pol     = r_pol;
  assign o_errNoY  = r_errNoY;

endmodule

// File: rtl/dvs_aer_multi_event_interface.sv
// Multi-channel DVS AER receiver: per-channel handshakes feed a round-robin
// arbiter and shared event FIFO drained over a req/grant bus. Optional DVS_TIMESTAMP_EN.
module dvs_aer_multi_event_interface
  import dvs_ravens_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int ADDR_BITS      = 9,
  parameter int FIFO_DEPTH     = 4,
  parameter int Y_SETUP_CYCLES = 5,
  localparam int EVENT_W       = event_w(ADDR_BITS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH*(ADDR_BITS+1)-1:0] aer,
  input  logic [NUM_CH-1:0]             xsel,
  input  logic [NUM_CH-1:0]             req,
  output logic [NUM_CH-1:0]             ack,
  output logic                          fifo_req,
  input  logic                          fifo_grant,
  output logic                          fifo_bus_wr,
  output logic [EVENT_W-1:0]            fifo_event,
  output logic [NUM_CH-1:0]             err_no_y
);

  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int COUNT_W = PTR_W + 1;

  logic [NUM_CH-1:0]    w_pushReq;
  logic [NUM_CH-1:0]    w_grantVec;
  logic [ADDR_BITS-1:0] w_chX   [NUM_CH];
  logic [ADDR_BITS-1:0] w_chY   [NUM_CH];
  logic                 w_chPol [NUM_CH];

  logic [EVENT_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wrPtr;
  logic [PTR_W-1:0]     r_rdPtr;
  logic [COUNT_W-1:0]   r_count;
  logic [IDX_W-1:0]     r_lastWinner;
  logic [IDX_W-1:0]     w_winner;
  logic                 r_busWr;
  logic [EVENT_W-1:0]   r_event;
  logic [EVENT_W-1:0]   w_pushEvent;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_canPush;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    dvs_aer_rx_channel #(
      .ADDR_BITS      (ADDR_BITS),
      .Y_SETUP_CYCLES (Y_SETUP_CYCLES)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .i_aer     (aer[c*(ADDR_BITS+1) +: (ADDR_BITS+1)]),
      .i_xsel    (xsel[c]),
      .i_req     (req[c]),
      .i_grant   (w_grantVec[c]),
      .o_ack     (ack[c]),
      .o_pushReq (w_pushReq[c]),
      .o_x       (w_chX[c]),
      .o_y       (w_chY[c]),
      .o_pol     (w_chPol[c]),
      .o_errNoY  (err_no_y[c])
    );
  end

`ifdef DVS_TIMESTAMP_EN
  logic [TS_BITS-1:0] r_tsCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tsCnt <= '0;
    else     r_tsCnt <= r_tsCnt + TS_BITS'(1);
  end
`endif

  // A full FIFO still accepts a push in the cycle it pops; an empty FIFO
  // never pops, so a push into it only becomes visible a cycle later.
  assign w_pop     = (r_count != '0) && fifo_grant;
  assign w_canPush = (r_count != COUNT_W'(FIFO_DEPTH)) || w_pop;
  assign fifo_req  = (r_count != '0);

  // Round-robin search starts just past the previous winner.
  always_comb begin
    w_grantVec  = '0;
    w_push      = 1'b0;
    w_pushEvent = '0;
    w_winner    = r_lastWinner;
    for (int i = 1; i <= NUM_CH; i++) begin
      automatic int idx = (int'(r_lastWinner) + i) % NUM_CH;
      if (!w_push && w_canPush && w_pushReq[idx]) begin
        w_push          = 1'b1;
        w_grantVec[idx] = 1'b1;
        w_winner        = IDX_W'(idx);
`ifdef DVS_TIMESTAMP_EN
        w_pushEvent = {CH_ID_BITS'(idx), w_chY[idx], w_chX[idx], w_chPol[idx], r_tsCnt};
`else
        w_pushEvent = {CH_ID_BITS'(idx), w_chY[idx], w_chX[idx], w_chPol[idx]};
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= w_pushEvent;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr      <= '0;
      r_rdPtr      <= '0;
      r_count      <= '0;
      r_lastWinner <= IDX_W'(NUM_CH - 1);
      r_busWr      <= 1'b0;
      r_event      <= '0;
    end else begin
      r_busWr <= w_pop;
      if (w_push) begin
        r_wrPtr      <= r_wrPtr + PTR_W'(1);
        r_lastWinner <= w_winner;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
        r_event <= r_mem[r_rdPtr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + COUNT_W'(1);
        2'b01:   r_count <= r_count - COUNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign fifo_bus_wr = r_busWr;
  assign fifo_event  = r_event;

endmodule

// File: tb/tb_dvs_aer_multi_event_interface.sv
// Scoreboard bench for dvs_aer_multi_event_interface: expected events are queued
// as senders are driven and matched against every fifo_bus_wr pulse.
module tb_dvs_aer_multi_event_interface;
  import dvs_ravens_pkg::*;

  localparam int NUM_CH         = 2;
  localparam int ADDR_BITS      = 9;
  localparam int FIFO_DEPTH     = 4;
  localparam int Y_SETUP_CYCLES = 5;
  localparam int EVENT_W        = event_w(ADDR_BITS);
  localparam int CLK_PERIOD     = 10;

  logic                           clk;
  logic                           rst;
  logic [NUM_CH*(ADDR_BITS+1)-1:0] aer;
  logic [NUM_CH-1:0]              xsel;
  logic [NUM_CH-1:0]              req;
  logic [NUM_CH-1:0]              ack;
  logic                           fifo_req;
  logic                           fifo_grant;
  logic                           fifo_bus_wr;
  logic [EVENT_W-1:0]             fifo_event;
  logic [NUM_CH-1:0]              err_no_y;

  logic [ADDR_BITS:0] aerCh  [NUM_CH];
  logic               xselCh [NUM_CH];
  logic               reqCh  [NUM_CH];

  dvs_event_t expQ[$];
  int checkCount = 0;
  int failCount  = 0;
  int writeCount = 0;

  dvs_aer_multi_event_interface #(
    .NUM_CH         (NUM_CH),
    .ADDR_BITS      (ADDR_BITS),
    .FIFO_DEPTH     (FIFO_DEPTH),
    .Y_SETUP_CYCLES (Y_SETUP_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .aer         (aer),
    .xsel        (xsel),
    .req         (req),
    .ack         (ack),
    .fifo_req    (fifo_req),
    .fifo_grant  (fifo_grant),
    .fifo_bus_wr (fifo_bus_wr),
    .fifo_event  (fifo_event),
    .err_no_y    (err_no_y)
  );

  initial clk = 1'b0;
  always #(CLK_PERIOD / 2) clk = ~clk;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      aer[c*(ADDR_BITS+1) +: (ADDR_BITS+1)] = aerCh[c];
      xsel[c] = xselCh[c];
      req[c]  = reqCh[c];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic dvs_event_t mkEvent(input int ch, input int y, input int x, input logic pol);
    dvs_event_t e;
    e.chId = CH_ID_BITS'(ch);
    e.y    = DEF_ADDR_BITS'(y);
    e.x    = DEF_ADDR_BITS'(x);
    e.pol  = pol;
    return e;
  endfunction

  // Every write strobe must match the oldest outstanding expected event.
  always @(negedge clk) begin
    if (!rst && fifo_bus_wr) begin
      dvs_event_t obs;
      writeCount++;
`ifdef DVS_TIMESTAMP_EN
      obs = fifo_event[EVENT_W-1:TS_BITS];
`else
      obs = fifo_event;
`endif
      if (expQ.size() == 0)
        checkOutput("unexpectedWrite", 32'(fifo_bus_wr), 32'd0);
      else
        checkOutput("event", 32'(obs), 32'(expQ.pop_front()));
    end
  end

  task automatic waitAck(input int ch, input logic level, input string tag);
    int n = 0;
    while (ack[ch] !== level && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (ack[ch] !== level) checkOutput(tag, 32'(ack[ch]), 32'(level));
  endtask

  // Full four-phase handshake on one channel; returns req-to-ack time.
  task automatic applyStimulus(input int ch, input logic isX, input logic [ADDR_BITS:0] word,
                               output longint latency);
    longint t0;
    aerCh[ch]  = word;
    xselCh[ch] = isX;
    reqCh[ch]  = 1'b1;
    t0 = longint'($time);
    waitAck(ch, 1'b1, "ackRiseTimeout");
    latency = longint'($time) - t0;
    reqCh[ch] = 1'b0;
    waitAck(ch, 1'b0, "ackFallTimeout");
  endtask

  function automatic logic [ADDR_BITS:0] xWord(input int x, input logic pol);
    return {ADDR_BITS'(x), pol};
  endfunction

  function automatic logic [ADDR_BITS:0] yWord(input int y);
    return {1'b0, ADDR_BITS'(y)};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    longint lat, latB;
    int     wcSnap;

    rst        = 1'b1;
    fifo_grant = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      aerCh[c]  = '0;
      xselCh[c] = 1'b0;
      reqCh[c]  = 1'b0;
    end
    idle(4);
    checkOutput("rstAck",      32'(ack),         32'd0);
    checkOutput("rstFifoReq",  32'(fifo_req),    32'd0);
    checkOutput("rstBusWr",    32'(fifo_bus_wr), 32'd0);
    checkOutput("rstEvent",    32'(fifo_event),  32'd0);
    checkOutput("rstErrNoY",   32'(err_no_y),    32'd0);
    rst = 1'b0;
    idle(3);

    $display("[TB] single event on ch0");
    fifo_grant = 1'b1;
    applyStimulus(0, 1'b0, yWord('h05A), lat);
    checkOutput("yAckLatencyAtLeast50", 32'(lat >= 50), 32'd1);
    expQ.push_back(mkEvent(0, 'h05A, 'h0C3, 1'b1));
    applyStimulus(0, 1'b1, xWord('h0C3, 1'b1), lat);
    idle(10);
    checkOutput("singlePending", 32'(expQ.size()), 32'd0);
    checkOutput("singleWrites",  32'(writeCount),  32'd1);

    $display("[TB] X word without Y on ch1");
    applyStimulus(1, 1'b1, xWord('h011, 1'b0), lat);
    idle(10);
    checkOutput("errNoY", 32'(err_no_y), 32'b10);
    checkOutput("noYWrites", 32'(writeCount), 32'd1);

    $display("[TB] round-robin ties");
    applyStimulus(1, 1'b0, yWord('h1F0), lat);
    expQ.push_back(mkEvent(1, 'h1F0, 'h022, 1'b0));
    applyStimulus(1, 1'b1, xWord('h022, 1'b0), lat);
    expQ.push_back(mkEvent(0, 'h05A, 'h100, 1'b1));
    expQ.push_back(mkEvent(1, 'h1F0, 'h0FF, 1'b1));
    fork
      applyStimulus(0, 1'b1, xWord('h100, 1'b1), lat);
      applyStimulus(1, 1'b1, xWord('h0FF, 1'b1), latB);
    join
    expQ.push_back(mkEvent(0, 'h05A, 'h003, 1'b0));
    applyStimulus(0, 1'b1, xWord('h003, 1'b0), lat);
    expQ.push_back(mkEvent(1, 'h1F0, 'h055, 1'b1));
    expQ.push_back(mkEvent(0, 'h05A, 'h1AA, 1'b0));
    fork
      applyStimulus(0, 1'b1, xWord('h1AA, 1'b0), lat);
      applyStimulus(1, 1'b1, xWord('h055, 1'b1), latB);
    join
    idle(10);
    checkOutput("tiePending", 32'(expQ.size()), 32'd0);
    checkOutput("tieWrites",  32'(writeCount),  32'd7);

    $display("[TB] backpressure with grant held low");
    fifo_grant = 1'b0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      expQ.push_back(mkEvent(0, 'h05A, 'h040 + k, k[0]));
      applyStimulus(0, 1'b1, xWord('h040 + k, k[0]), lat);
    end
    expQ.push_back(mkEvent(0, 'h05A, 'h0EE, 1'b1));
    wcSnap = writeCount;
    fork
      applyStimulus(0, 1'b1, xWord('h0EE, 1'b1), lat);
      begin
        idle(30);
        checkOutput("fifthAckWithheld", 32'(ack[0]),    32'd0);
        checkOutput("fullFifoReq",      32'(fifo_req),  32'd1);
        checkOutput("noWriteWithoutGrant", 32'(writeCount), 32'(wcSnap));
        fifo_grant = 1'b1;
      end
    join
    idle(15);
    checkOutput("backpressurePending", 32'(expQ.size()), 32'd0);
    checkOutput("fifoReqDrained",      32'(fifo_req),    32'd0);

    $display("[TB] reset with buffered events");
    fifo_grant = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expQ.push_back(mkEvent(0, 'h05A, 'h070 + k, 1'b0));
      applyStimulus(0, 1'b1, xWord('h070 + k, 1'b0), lat);
    end
    checkOutput("preResetFifoReq", 32'(fifo_req), 32'd1);
    aerCh[1]  = xWord('h033, 1'b1);
    xselCh[1] = 1'b1;
    reqCh[1]  = 1'b1;
    rst       = 1'b1;
    #1;
    checkOutput("resetFifoReq", 32'(fifo_req),    32'd0);
    checkOutput("resetAck",     32'(ack),         32'd0);
    checkOutput("resetBusWr",   32'(fifo_bus_wr), 32'd0);
    checkOutput("resetErrNoY",  32'(err_no_y),    32'd0);
    expQ.delete();
    idle(3);
    wcSnap     = writeCount;
    fifo_grant = 1'b1;
    rst        = 1'b0;
    waitAck(1, 1'b1, "heldReqAckTimeout");
    checkOutput("heldReqErrNoY", 32'(err_no_y), 32'b10);
    reqCh[1] = 1'b0;
    waitAck(1, 1'b0, "heldReqAckFallTimeout");
    idle(20);
    checkOutput("noStaleWrites",  32'(writeCount), 32'(wcSnap));
    checkOutput("postResetFifoReq", 32'(fifo_req), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
